// File: rtl/drive_cmd_ctrl.sv
// Drive command decoder: UART bytes '0'..'3' select wheel duty targets, with watchdog stop and PWM outputs.
// Define DRIVE_RAMP_EN to ramp duties by 1 per RAMP_CLKS; otherwise duties load their targets directly.
module drive_cmd_ctrl #(
  parameter int         PWM_PRESCALE  = 196,
  parameter int         RAMP_CLKS     = 50000,
  parameter int         WATCHDOG_CLKS = 25000000,
  parameter logic [7:0] DUTY_HI       = 8'd200,
  parameter logic [7:0] DUTY_LO       = 8'd80
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic [1:0] o_Cmd,
  output logic [7:0] o_Duty_L,
  output logic [7:0] o_Duty_R,
  output logic       o_PWM_L,
  output logic       o_PWM_R,
  output logic       o_Timeout,
  output logic       o_Cmd_Err
);

  localparam logic [1:0] ST_STOPPED = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  localparam int PS_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam int WD_W = (WATCHDOG_CLKS > 1) ? $clog2(WATCHDOG_CLKS) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PWM_PRESCALE - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CLKS - 1);

  logic [1:0]      state_reg, state_next;
  logic [1:0]      cmd_reg, cmd_next;
  logic [7:0]      tgt_l_reg, tgt_l_next, tgt_r_reg, tgt_r_next;
  logic [WD_W-1:0] wd_reg, wd_next, wd_inc;
  logic            err_reg, err_next;
  logic [7:0]      duty_l_reg, duty_l_next, duty_r_reg, duty_r_next;
  logic [PS_W-1:0] ps_reg;
  logic [7:0]      phase_reg;
  logic            pwm_l_reg, pwm_r_reg;

  logic            known;
  logic [1:0]      dec_cmd;
  logic [7:0]      dec_l, dec_r;

  always_comb begin
    known   = 1'b1;
    dec_cmd = 2'd3;
    dec_l   = 8'd0;
    dec_r   = 8'd0;
    case (i_Rx_Byte)
      8'd48:   begin dec_cmd = 2'd0; dec_l = DUTY_LO; dec_r = DUTY_HI; end
      8'd49:   begin dec_cmd = 2'd1; dec_l = DUTY_HI; dec_r = DUTY_HI; end
      8'd50:   begin dec_cmd = 2'd2; dec_l = DUTY_HI; dec_r = DUTY_LO; end
      8'd51:   dec_cmd = 2'd3;
      default: known = 1'b0;
    endcase
  end

  assign wd_inc = (wd_reg == WD_LAST) ? wd_reg : wd_reg + 1'b1;

  // A valid command takes priority over a watchdog expiry in the same cycle.
  always_comb begin
    state_next = state_reg;
    cmd_next   = cmd_reg;
    tgt_l_next = tgt_l_reg;
    tgt_r_next = tgt_r_reg;
    wd_next    = wd_reg;
    err_next   = i_Rx_DV && !known;
    if (i_Rx_DV && known) begin
      wd_next    = '0;
      cmd_next   = dec_cmd;
      tgt_l_next = dec_l;
      tgt_r_next = dec_r;
      state_next = (dec_cmd == 2'd3) ? ST_STOPPED : ST_RUN;
    end else if (state_reg == ST_RUN) begin
      wd_next = wd_inc;
      if (wd_inc == WD_LAST) begin
        state_next = ST_TIMEOUT;
        cmd_next   = 2'd3;
        tgt_l_next = 8'd0;
        tgt_r_next = 8'd0;
      end
    end
  end

`ifdef DRIVE_RAMP_EN
  localparam int RP_W = (RAMP_CLKS > 1) ? $clog2(RAMP_CLKS) : 1;
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(RAMP_CLKS - 1);

  logic [RP_W-1:0] ramp_reg;
  logic            ramp_tick;

  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur < tgt)      return cur + 8'd1;
    else if (cur > tgt) return cur - 8'd1;
    else                return cur;
  endfunction

  assign ramp_tick = (ramp_reg == RP_LAST);

  always_ff @(posedge i_Clock) begin
    if (i_Reset) ramp_reg <= '0;
    else         ramp_reg <= ramp_tick ? '0 : ramp_reg + 1'b1;
  end

  // Stepping toward the next target lets a tick coinciding with a new command move the right way.
  assign duty_l_next = ramp_tick ? step_toward(duty_l_reg, tgt_l_next) : duty_l_reg;
  assign duty_r_next = ramp_tick ? step_toward(duty_r_reg, tgt_r_next) : duty_r_reg;
`else
  assign duty_l_next = tgt_l_reg;
  assign duty_r_next = tgt_r_reg;
`endif

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_reg  <= ST_STOPPED;
      cmd_reg    <= 2'd3;
      tgt_l_reg  <= 8'd0;
      tgt_r_reg  <= 8'd0;
      wd_reg     <= '0;
      err_reg    <= 1'b0;
      duty_l_reg <= 8'd0;
      duty_r_reg <= 8'd0;
      ps_reg     <= '0;
      phase_reg  <= 8'd0;
      pwm_l_reg  <= 1'b0;
      pwm_r_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cmd_reg    <= cmd_next;
      tgt_l_reg  <= tgt_l_next;
      tgt_r_reg  <= tgt_r_next;
      wd_reg     <= wd_next;
      err_reg    <= err_next;
      duty_l_reg <= duty_l_next;
      duty_r_reg <= duty_r_next;
      if (ps_reg == PS_LAST) begin
        ps_reg    <= '0;
        phase_reg <= phase_reg + 8'd1;
      end else begin
        ps_reg <= ps_reg + 1'b1;
      end
      pwm_l_reg <= (phase_reg < duty_l_reg);
      pwm_r_reg <= (phase_reg < duty_r_reg);
    end
  end

  assign o_Cmd     = cmd_reg;
  assign o_Duty_L  = duty_l_reg;
  assign o_Duty_R  = duty_r_reg;
  assign o_PWM_L   = pwm_l_reg;
  assign o_PWM_R   = pwm_r_reg;
  assign o_Timeout = (state_reg == ST_TIMEOUT);
  assign o_Cmd_Err = err_reg;

endmodule

// File: tb/tb_drive_cmd_ctrl.sv
// Directed bench for drive_cmd_ctrl with fast parameters (prescale 1, ramp 2, watchdog 1000).
module tb_drive_cmd_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic [1:0] cmd;
  logic [7:0] duty_l, duty_r;
  logic       pwm_l, pwm_r, timeout, cmd_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  drive_cmd_ctrl #(
    .PWM_PRESCALE (1),
    .RAMP_CLKS    (2),
    .WATCHDOG_CLKS(1000),
    .DUTY_HI      (8'd200),
    .DUTY_LO      (8'd80)
  ) dut (
    .i_Clock  (clk),
    .i_Reset  (rst),
    .i_Rx_DV  (rx_dv),
    .i_Rx_Byte(rx_byte),
    .o_Cmd    (cmd),
    .o_Duty_L (duty_l),
    .o_Duty_R (duty_r),
    .o_PWM_L  (pwm_l),
    .o_PWM_R  (pwm_r),
    .o_Timeout(timeout),
    .o_Cmd_Err(cmd_err)
  );

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic bit between(input int v, input int a, input int b);
    return (a <= b) ? (v >= a && v <= b) : (v >= b && v <= a);
  endfunction

  // Strobe lands at the posedge between the two negedges; returns at the negedge of cycle N+1.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv   = 1'b0;
  endtask

  task automatic wait_duty(input int el, input int er, input string name);
    int  sl, sr, pl, pr, n, maxd;
    bit  step_ok, chg, chg_prev;
    sl = duty_l; sr = duty_r; pl = sl; pr = sr;
    n = 0; step_ok = 1'b1; chg_prev = 1'b0;
    while ((int'(duty_l) != el || int'(duty_r) != er) && n < 3000) begin
      @(negedge clk);
      n++;
`ifdef DRIVE_RAMP_EN
      chg = (int'(duty_l) != pl) || (int'(duty_r) != pr);
      if (absdiff(duty_l, pl) > 1 || absdiff(duty_r, pr) > 1 || (chg && chg_prev) ||
          !between(duty_l, sl, el) || !between(duty_r, sr, er))
        step_ok = 1'b0;
      chg_prev = chg;
`endif
      pl = duty_l; pr = duty_r;
    end
    total++;
    if (int'(duty_l) != el || int'(duty_r) != er) begin
      bad++;
      $display("FAIL %s_settle: L=%0d R=%0d expected L=%0d R=%0d", name, duty_l, duty_r, el, er);
    end
`ifdef DRIVE_RAMP_EN
    total++;
    if (!step_ok) begin
      bad++;
      $display("FAIL %s_step: duty moved by more than 1 per 2 clocks or left range %0d/%0d..%0d/%0d",
               name, sl, sr, el, er);
    end
    maxd = (absdiff(sl, el) > absdiff(sr, er)) ? absdiff(sl, el) : absdiff(sr, er);
    if (maxd > 0) begin
      total++;
      if (n < (maxd - 1) * 2 || n > maxd * 2 + 2) begin
        bad++;
        $display("FAIL %s_ramp_time: took %0d clocks, expected %0d..%0d", name, n, (maxd - 1) * 2, maxd * 2 + 2);
      end
    end
`endif
  endtask

  task automatic check_pwm(input int el, input int er, input string name);
    int hl, hr;
    hl = 0; hr = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (pwm_l === 1'b1) hl++;
      if (pwm_r === 1'b1) hr++;
    end
    total++;
    if (hl != el || hr != er) begin
      bad++;
      $display("FAIL %s_pwm: high counts L=%0d R=%0d expected L=%0d R=%0d", name, hl, hr, el, er);
    end
  endtask

  task automatic check_reset_values(input string name);
    total++;
    if (cmd !== 2'd3 || duty_l !== 8'd0 || duty_r !== 8'd0 || pwm_l !== 1'b0 ||
        pwm_r !== 1'b0 || timeout !== 1'b0 || cmd_err !== 1'b0) begin
      bad++;
      $display("FAIL %s: cmd=%0d L=%0d R=%0d pwm=%b%b to=%b err=%b expected cmd=3 L=0 R=0 pwm=00 to=0 err=0",
               name, cmd, duty_l, duty_r, pwm_l, pwm_r, timeout, cmd_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'd0;
    repeat (2) @(negedge clk);
    rx_dv = 1'b1; rx_byte = 8'd49;
    @(negedge clk);
    rx_dv = 1'b0; rst = 1'b0;
    check_reset_values("reset");
    @(negedge clk);
    total++;
    if (cmd !== 2'd3) begin
      bad++;
      $display("FAIL reset_dv_ignored: cmd=%0d expected 3", cmd);
    end
  endtask

  task automatic test_right();
    send_byte(8'd50);
    total++;
    if (cmd !== 2'd2 || cmd_err !== 1'b0 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL right_cmd: cmd=%0d err=%b to=%b expected cmd=2 err=0 to=0", cmd, cmd_err, timeout);
    end
`ifndef DRIVE_RAMP_EN
    total++;
    if (duty_l !== 8'd0 || duty_r !== 8'd0) begin
      bad++;
      $display("FAIL right_n1: L=%0d R=%0d expected L=0 R=0", duty_l, duty_r);
    end
    @(negedge clk);
    total++;
    if (duty_l !== 8'd200 || duty_r !== 8'd80) begin
      bad++;
      $display("FAIL right_n2: L=%0d R=%0d expected L=200 R=80", duty_l, duty_r);
    end
`endif
    wait_duty(200, 80, "right");
    check_pwm(200, 80, "right");
  endtask

  task automatic test_straight();
    send_byte(8'd49);
    total++;
    if (cmd !== 2'd1) begin
      bad++;
      $display("FAIL straight_cmd: cmd=%0d expected 1", cmd);
    end
`ifndef DRIVE_RAMP_EN
    total++;
    if (duty_r !== 8'd80) begin
      bad++;
      $display("FAIL straight_n1: R=%0d expected 80", duty_r);
    end
    @(negedge clk);
    total++;
    if (duty_l !== 8'd200 || duty_r !== 8'd200) begin
      bad++;
      $display("FAIL straight_n2: L=%0d R=%0d expected L=200 R=200", duty_l, duty_r);
    end
`endif
    wait_duty(200, 200, "straight");
    check_pwm(200, 200, "straight");
  endtask

  task automatic test_timeout();
    int n;
    send_byte(8'd48);
    n = 0;
    while (timeout !== 1'b1 && n < 1500) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n != 999) begin
      bad++;
      $display("FAIL timeout_latency: rose after %0d clocks expected 999", n);
    end
    total++;
    if (cmd !== 2'd3 || duty_l !== 8'd80 || duty_r !== 8'd200) begin
      bad++;
      $display("FAIL timeout_state: cmd=%0d L=%0d R=%0d expected cmd=3 L=80 R=200", cmd, duty_l, duty_r);
    end
    wait_duty(0, 0, "timeout_stop");
    send_byte(8'd49);
    total++;
    if (timeout !== 1'b0 || cmd !== 2'd1) begin
      bad++;
      $display("FAIL timeout_exit: to=%b cmd=%0d expected to=0 cmd=1", timeout, cmd);
    end
    wait_duty(200, 200, "timeout_resume");
  endtask

  task automatic test_cmd_err();
    int n;
    send_byte(8'd49);
    repeat (500) @(negedge clk);
    send_byte(8'h41);
    total++;
    if (cmd_err !== 1'b1 || cmd !== 2'd1 || duty_l !== 8'd200 || duty_r !== 8'd200) begin
      bad++;
      $display("FAIL cmd_err_pulse: err=%b cmd=%0d L=%0d R=%0d expected err=1 cmd=1 L=200 R=200",
               cmd_err, cmd, duty_l, duty_r);
    end
    n = 0;
    while (timeout !== 1'b1 && n < 1500) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        total++;
        if (cmd_err !== 1'b0) begin
          bad++;
          $display("FAIL cmd_err_width: err=%b expected 0 one cycle later", cmd_err);
        end
      end
    end
    total++;
    if (n != 497) begin
      bad++;
      $display("FAIL cmd_err_watchdog: timeout after %0d more clocks expected 497", n);
    end
  endtask

  task automatic test_race();
    send_byte(8'd49);
    repeat (997) @(negedge clk);
    send_byte(8'd50);
    total++;
    if (timeout !== 1'b0 || cmd !== 2'd2) begin
      bad++;
      $display("FAIL race_cmd_wins: to=%b cmd=%0d expected to=0 cmd=2", timeout, cmd);
    end
    repeat (5) @(negedge clk);
    total++;
    if (timeout !== 1'b0) begin
      bad++;
      $display("FAIL race_wd_cleared: to=%b expected 0", timeout);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    rx_dv = 1'b1; rx_byte = 8'd48;
    @(negedge clk);
    rx_byte = 8'd50;
    total++;
    if (cmd !== 2'd0) begin
      bad++;
      $display("FAIL b2b_first: cmd=%0d expected 0", cmd);
    end
    @(negedge clk);
    rx_dv = 1'b0;
    total++;
    if (cmd !== 2'd2) begin
      bad++;
      $display("FAIL b2b_last: cmd=%0d expected 2", cmd);
    end
  endtask

  task automatic test_reset_mid();
    send_byte(8'd48);
    repeat (21) @(negedge clk);
    rst = 1'b1; rx_dv = 1'b1; rx_byte = 8'd49;
    @(negedge clk);
    check_reset_values("reset_mid");
    rst = 1'b0; rx_dv = 1'b0;
    @(negedge clk);
    total++;
    if (cmd !== 2'd3 || duty_l !== 8'd0 || duty_r !== 8'd0) begin
      bad++;
      $display("FAIL reset_mid_after: cmd=%0d L=%0d R=%0d expected cmd=3 L=0 R=0", cmd, duty_l, duty_r);
    end
  endtask

  initial begin
    rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'd0;
    test_reset();
    $display("test_reset finished: total=%0d", total);
    test_right();
    $display("test_right finished: total=%0d", total);
    test_straight();
    $display("test_straight finished: total=%0d", total);
    test_timeout();
    $display("test_timeout finished: total=%0d", total);
    test_cmd_err();
    $display("test_cmd_err finished: total=%0d", total);
    test_race();
    $display("test_race finished: total=%0d", total);
    test_back_to_back();
    $display("test_back_to_back finished: total=%0d", total);
    test_reset_mid();
    $display("test_reset_mid finished: total=%0d", total);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/drive_cmd_ctrl.md
# drive_cmd_ctrl

Downstream consumer of the UART receiver in the line-follower datapath. Takes each received byte and its one-cycle valid strobe, decodes the ASCII drive commands '0'/'1'/'2'/'3', and ramps left/right motor duty cycles toward per-command targets. It generates the two motor PWM outputs and stops both motors if no valid command arrives within a watchdog window.

## Interface
- PWM_PRESCALE, default 196: clocks per PWM phase step; the 256-step period is about 1 kHz at 50 MHz.
- RAMP_CLKS, default 50000: clocks between successive ±1 duty steps.
- WATCHDOG_CLKS, default 25000000: clocks without a valid command before timeout (0.5 s).
- DUTY_HI, default 200: fast-wheel duty (0..255).
- DUTY_LO, default 80: slow-wheel duty (0..255); must be less than or equal to DUTY_HI.
- i_Clock  in  1  system clock, 50 MHz.
- i_Reset  in  1  synchronous, active-high reset.
- i_Rx_DV  in  1  one-cycle strobe; i_Rx_Byte is valid on this cycle.
- i_Rx_Byte  in  8  received byte.
- o_Cmd  out  2  active command: 0 left, 1 straight, 2 right, 3 stop.
- o_Duty_L  out  8  current left duty.
- o_Duty_R  out  8  current right duty.
- o_PWM_L  out  1  left motor PWM.
- o_PWM_R  out  1  right motor PWM.
- o_Timeout  out  1  high while in TIMEOUT state.
- o_Cmd_Err  out  1  one-cycle pulse on an unrecognised byte.

## Operation
- Decode on i_Rx_DV:
  - 8'd48 → left (L=DUTY_LO, R=DUTY_HI)
  - 8'd49 → straight (L=R=DUTY_HI)
  - 8'd50 → right (L=DUTY_HI, R=DUTY_LO)
  - 8'd51 → stop (L=R=0)
  - Any other byte: pulse o_Cmd_Err; target, o_Cmd, state and watchdog are unchanged.
- States:
  - STOPPED: reset state. o_Cmd=3, targets 0. A valid move command (48–50) → RUN. Byte 51 keeps the block in STOPPED.
  - RUN: a valid move command updates the targets. Byte 51 → STOPPED. Watchdog count reaching WATCHDOG_CLKS-1 → TIMEOUT.
  - TIMEOUT: targets forced to 0, o_Cmd=3, o_Timeout=1. A valid move command → RUN. Byte 51 → STOPPED.
- Watchdog:
  - Counts clocks only in RUN.
  - Clears on every valid command (48–51) and on entering RUN.
  - Saturates; it never wraps.
- Ramp:
  - A free-running tick fires every RAMP_CLKS clocks.
  - On each tick, each duty moves 1 toward its target.
  - A duty equal to its target holds; there is no overshoot, and values never wrap below 0 or above 255.
  - A target change mid-ramp takes effect at the next tick from the current duty.
- PWM:
  - An 8-bit phase counter advances every PWM_PRESCALE clocks and wraps 255→0.
  - o_PWM_x = (phase < o_Duty_x), registered.
  - Duty 0 gives a constant low output.
- Simultaneous events:
  - Valid command on the same cycle the watchdog expires: the command wins and the watchdog clears.
  - Ramp tick on the same cycle as a target change: the step is taken toward the new target.

## Timing
- Reset values: o_Cmd=3; o_Duty_L/R=0; o_PWM_L/R=0; o_Timeout=0; o_Cmd_Err=0. The phase, prescale, ramp and watchdog counters reset to 0; state resets to STOPPED.
- Reset asserted mid-operation forces all of the above on the next clock edge. Any i_Rx_DV during reset is ignored.
- After i_Rx_DV at cycle N:
  - o_Cmd, the targets and the state are updated at N+1.
  - o_Cmd_Err is high for cycle N+1 only.
- Timeout:
  - o_Timeout rises at the edge where the watchdog count reaches WATCHDOG_CLKS-1.
  - o_Timeout falls one cycle after the valid command that exits TIMEOUT.
- o_Duty_x changes one cycle after a ramp tick. o_PWM_x lags phase/duty by one cycle.
- i_Rx_DV is a single-cycle pulse. Back-to-back strobes on consecutive cycles are each decoded; the last one wins.

## Configuration
- DRIVE_RAMP_EN defined: duty ramps at ±1 per RAMP_CLKS, as described above.
- DRIVE_RAMP_EN undefined:
  - The ramp counter is removed.
  - o_Duty_x loads its target directly, one cycle after the target changes; o_Duty_x is updated at N+2 after i_Rx_DV at cycle N.
  - All other behaviour is identical.

## Test plan
All scenarios use PWM_PRESCALE=1, RAMP_CLKS=2, WATCHDOG_CLKS=1000, DUTY_HI=200, DUTY_LO=80, with DRIVE_RAMP_EN defined unless stated.
- Reset, then pulse i_Rx_DV with byte 50 → o_Cmd=2 one cycle later. o_Duty_L reaches 200 and o_Duty_R reaches 80, each in steps of 1 per 2 clocks, with no overshoot.
- Byte 49 after byte 50 has settled → o_Duty_R ramps 80→200 and o_Duty_L holds at 200. o_PWM_R high count is 200 of every 256 clocks once settled.
- Byte 48 settled, then no further strobes → o_Timeout=1 after 1000 clocks in RUN and both duties ramp to 0. Byte 49 then → o_Timeout=0 and the block returns to RUN.
- Byte 8'h41 while in RUN → one-cycle o_Cmd_Err pulse; o_Cmd and the duties are unchanged; the watchdog is not cleared.
- Byte 50 on the exact cycle the watchdog expires → no timeout and o_Cmd=2. Reset asserted mid-ramp → all outputs at reset values on the next edge.
- With DRIVE_RAMP_EN undefined: byte 49 → o_Duty_L=o_Duty_R=200 two cycles after i_Rx_DV.
